reg_file_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_clr_fsm.sv | 67 ++++++
 rtl/reg_file_param.sv | 64 ++++++
 tb/tb_reg_file_param.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Holds the clear-sweep state encoding and the address-width helper.
package regfile_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep sequencer: walks registers 1..NREGS-1, zeroing one per cycle.
//   state    | meaning
//   ST_IDLE  | waiting for clr_start; write port owns the array
//   ST_CLEAR | zeroing reg[r_ptr] this cycle; busy asserted
//   ST_DONE  | one-cycle clr_done pulse; clr_start ignored
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clr_start,
  output logic                      busy,
  output logic                      clr_done,
  output logic                      clr_we,
  output logic [clog2(NREGS)-1:0]   clr_addr
);

  localparam int              AW   = clog2(NREGS);
  localparam logic [AW-1:0]   LAST = AW'(NREGS - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    busy        = 1'b0;
    clr_done    = 1'b0;
    clr_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clr_start) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = AW'(1);
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_we    = 1'b1;
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        clr_done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign clr_addr = r_ptr;

endmodule

// File: rtl/reg_file_param.sv
// NREGS x WIDTH register file: two combinational read ports, one write port,
// register 0 hardwired to zero, optional write bypass and a sequenced clear.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter bit BYPASS = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [clog2(NREGS)-1:0]   rr1,
  input  logic [clog2(NREGS)-1:0]   rr2,
  input  logic [clog2(NREGS)-1:0]   wr,
  input  logic [WIDTH-1:0]          wd,
  input  logic                      regwrite,
  input  logic                      clr_start,
  output logic [WIDTH-1:0]          rd1,
  output logic [WIDTH-1:0]          rd2,
  output logic                      busy,
  output logic                      clr_done
);

  localparam int AW = clog2(NREGS);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_wen;

  // The sweep owns the array while busy, so the write port is gated off.
  assign w_wen = regwrite && !busy && (wr != '0);

  regfile_clr_fsm #(
    .NREGS (NREGS)
  ) u_clr_fsm (
    .clock     (clock),
    .reset     (reset),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (w_wen) begin
      r_regs[wr] <= wd;
    end
  end

  // w_wen already excludes address 0, so bypass can never expose a reg-0 write.
  always_comb begin
    rd1 = (rr1 == '0) ? '0 : r_regs[rr1];
    rd2 = (rr2 == '0) ? '0 : r_regs[rr2];
    if (BYPASS && w_wen && (wr == rr1)) rd1 = wd;
    if (BYPASS && w_wen && (wr == rr2)) rd2 = wd;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: one bypassing and one non-bypassing
// instance share stimulus; a monitor compares against a reference model.
module tb_reg_file_param;

  localparam int NR = 4;

  logic        clock;
  logic        reset;
  logic [1:0]  rr1, rr2, wr;
  logic [15:0] wd;
  logic        regwrite, clr_start;
  logic [15:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy, clr_done, busy_nb, clr_done_nb;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] rd1, rd2, rd1n, rd2n;
    logic        busy, done;
  } exp_t;

  exp_t q[$];

  logic [15:0] m_regs [NR];
  int          m_pos;
  bit          m_done;

  reg_file_param #(.WIDTH(16), .NREGS(NR), .BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .wd(wd),
    .regwrite(regwrite), .clr_start(clr_start), .rd1(rd1), .rd2(rd2),
    .busy(busy), .clr_done(clr_done)
  );

  reg_file_param #(.WIDTH(16), .NREGS(NR), .BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .wd(wd),
    .regwrite(regwrite), .clr_start(clr_start), .rd1(rd1_nb), .rd2(rd2_nb),
    .busy(busy_nb), .clr_done(clr_done_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("rd1",         rd1,                e.rd1);
        check("rd2",         rd2,                e.rd2);
        check("rd1_nobypass", rd1_nb,            e.rd1n);
        check("rd2_nobypass", rd2_nb,            e.rd2n);
        check("busy",        {15'd0, busy},      {15'd0, e.busy});
        check("clr_done",    {15'd0, clr_done},  {15'd0, e.done});
        check("busy_nobypass", {15'd0, busy_nb}, {15'd0, e.busy});
        check("clr_done_nobypass", {15'd0, clr_done_nb}, {15'd0, e.done});
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
    m_pos  = 0;
    m_done = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict outputs, then advance the model.
  task automatic step(input bit rst, input bit we, input logic [1:0] a_wr,
                      input logic [15:0] d, input logic [1:0] a1,
                      input logic [1:0] a2, input bit cs);
    exp_t e;
    bit   wen;
    reset = rst; regwrite = we; wr = a_wr; wd = d; rr1 = a1; rr2 = a2; clr_start = cs;
    wen    = we && (m_pos == 0) && (a_wr != 2'd0);
    e.rd1n = m_regs[a1];
    e.rd2n = m_regs[a2];
    e.rd1  = (wen && a_wr == a1) ? d : m_regs[a1];
    e.rd2  = (wen && a_wr == a2) ? d : m_regs[a2];
    e.busy = (m_pos != 0);
    e.done = m_done;
    q.push_back(e);
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else if (m_pos != 0) begin
      m_regs[m_pos] = 16'h0;
      if (m_pos == NR - 1) begin
        m_pos  = 0;
        m_done = 1'b1;
      end else begin
        m_pos++;
      end
    end else begin
      if (wen) m_regs[a_wr] = d;
      if (cs && !m_done) m_pos = 1;
      m_done = 1'b0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; regwrite = 1'b0; clr_start = 1'b0;
    rr1 = 2'd0; rr2 = 2'd0; wr = 2'd0; wd = 16'h0;
    @(posedge clock);
    model_reset();
    #1;

    step(0, 0, 0, 16'h0,    1, 2, 0);
    step(0, 1, 1, 16'hA5A5, 1, 0, 0);
    step(0, 0, 0, 16'h0,    1, 0, 0);
    step(0, 1, 0, 16'hFFFF, 0, 0, 0);
    step(0, 0, 0, 16'h0,    0, 1, 0);
    step(0, 1, 2, 16'h1234, 2, 2, 0);
    step(0, 0, 0, 16'h0,    2, 2, 0);

    step(0, 1, 1, 16'h1111, 3, 1, 0);
    step(0, 1, 2, 16'h2222, 3, 2, 0);
    step(0, 1, 3, 16'h3333, 3, 1, 0);
    step(0, 0, 0, 16'h0,    3, 1, 1);
    step(0, 0, 0, 16'h0,    3, 1, 0);
    step(0, 1, 1, 16'hBEEF, 3, 1, 0);
    step(0, 0, 0, 16'h0,    3, 2, 1);
    step(0, 0, 0, 16'h0,    1, 2, 1);
    step(0, 0, 0, 16'h0,    3, 1, 0);
    step(0, 0, 0, 16'h0,    2, 0, 0);

    step(0, 1, 1, 16'h1111, 1, 2, 0);
    step(0, 1, 2, 16'h2222, 1, 2, 0);
    step(0, 1, 3, 16'h3333, 3, 2, 0);
    step(0, 1, 1, 16'h5A5A, 1, 3, 1);
    step(0, 0, 0, 16'h0,    3, 1, 0);
    step(1, 0, 0, 16'h0,    3, 2, 0);
    step(0, 0, 0, 16'h0,    1, 2, 0);
    step(0, 0, 0, 16'h0,    3, 1, 0);
    step(0, 0, 0, 16'h0,    2, 3, 0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0),
           $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)),
           16'($urandom),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 11) == 0));
    end

    @(negedge clock);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
